// File: rtl/keypad_time_entry_pkg.sv
// rtl/keypad_time_entry_pkg.sv - shared key codes, scanner states and keypad layout
package keypad_time_entry_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // One nibble per key, indexed by row*4+col (index 0 in the low nibble).
    // row0 = 1,2,3,A  row1 = 4,5,6,B  row2 = 7,8,9,C  row3 = *,0,#,D
    // with C=12, D=13, *=14, #=15.
    localparam logic [63:0] KEY_LAYOUT = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] base;
        base = {r, c, 2'b00};
        return KEY_LAYOUT[base +: 4];
    endfunction

endpackage

// File: rtl/keypad_time_entry_scanner.sv
// rtl/keypad_time_entry_scanner.sv - keypad column scanner with debounce
// Ports: clk, rst_n (sync active-low), row (active-low sense),
//        col (active-low one-hot drive), key_code, key_strobe (one-cycle).
module keypad_scanner
    import keypad_time_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_strobe
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

    scan_state_t   state;
    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] deb_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    key_row;
    logic [1:0]    low_row;
    logic [1:0]    next_idx;
    logic          tick;

    assign tick     = (pre_cnt == PRE_LAST);
    assign next_idx = col_idx + 2'd1;

    // Lowest-numbered row reading low wins when several are pressed.
    always_comb begin
        low_row = 2'd3;
        if (!row[0])      low_row = 2'd0;
        else if (!row[1]) low_row = 2'd1;
        else if (!row[2]) low_row = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SCAN;
            pre_cnt    <= '0;
            deb_cnt    <= '0;
            col_idx    <= 2'd0;
            col        <= 4'b1110;
            key_row    <= 2'd0;
            key_code   <= 4'd0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row != 4'hF) begin
                            // col stays frozen on the column that produced the hit
                            key_row <= low_row;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= next_idx;
                            col     <= ~(4'b0001 << next_idx);
                        end
                    end
                    DEBOUNCE: begin
                        if (!row[key_row]) begin
                            if (deb_cnt == DEB_LAST) begin
                                state      <= HELD;
                                deb_cnt    <= '0;
                                key_code   <= key_lookup(key_row, col_idx);
                                key_strobe <= 1'b1;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            deb_cnt <= '0;
                        end
                    end
                    HELD: begin
                        if (row == 4'hF) begin
                            if (deb_cnt == DEB_LAST) begin
                                state   <= SCAN;
                                deb_cnt <= '0;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            deb_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_time_entry.sv
// rtl/keypad_time_entry.sv - keypad MM:SS entry with conversion to seconds
// Ports: clk, rst_n (sync active-low), row/col keypad matrix, key_code,
//        key_strobe, entry_bcd {M1,M0,S1,S0}, value (seconds),
//        value_valid and entry_error one-cycle pulses.
module keypad_time_entry
    import keypad_time_entry_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [15:0] entry_bcd,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        entry_error
);

    logic        conv_pending;
    logic        conv_ok;
    logic [15:0] conv_sum;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
    logic [15:0] total;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_strobe (key_strobe)
    );

    always_comb begin
        minutes = {4'd0, entry_bcd[15:12]} * 8'd10 + {4'd0, entry_bcd[11:8]};
        seconds = {4'd0, entry_bcd[7:4]} * 8'd10 + {4'd0, entry_bcd[3:0]};
        total   = {8'd0, minutes} * 16'd60 + {8'd0, seconds};
    end

    // Enter is handled in two stages: the strobe cycle captures the result
    // and the seconds-digit check, the following edge commits or rejects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_bcd    <= 16'd0;
            value        <= 16'd0;
            value_valid  <= 1'b0;
            entry_error  <= 1'b0;
            conv_pending <= 1'b0;
            conv_ok      <= 1'b0;
            conv_sum     <= 16'd0;
        end else begin
            value_valid  <= 1'b0;
            entry_error  <= 1'b0;
            conv_pending <= 1'b0;
            if (key_strobe) begin
                if (key_code <= 4'd9) begin
                    entry_bcd <= {entry_bcd[11:0], key_code};
                end else if (key_code == KEY_CLEAR) begin
                    entry_bcd <= 16'd0;
                end else if (key_code == KEY_ENTER) begin
                    conv_pending <= 1'b1;
                    conv_ok      <= (entry_bcd[7:4] <= 4'd5);
                    conv_sum     <= total;
                end
            end
            if (conv_pending) begin
                if (conv_ok) begin
                    value       <= conv_sum;
                    value_valid <= 1'b1;
                    entry_bcd   <= 16'd0;
                end else begin
                    entry_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb/tb_keypad_time_entry.sv - directed self-checking bench for keypad_time_entry
module tb_keypad_time_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic [15:0] entry_bcd;
    logic [15:0] value;
    logic        value_valid;
    logic        entry_error;

    logic        pressed = 1'b0;
    logic [1:0]  prow = 2'd0;
    logic [1:0]  pcol = 2'd0;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    int n_strobe = 0, n_vv = 0, n_err = 0;
    int strb_cyc = 0, vv_cyc = 0, err_cyc = 0;

    keypad_time_entry #(.SCAN_DIV(4), .DEBOUNCE_TICKS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_strobe  (key_strobe),
        .entry_bcd   (entry_bcd),
        .value       (value),
        .value_valid (value_valid),
        .entry_error (entry_error)
    );

    always #5 clk = ~clk;

    // Keypad matrix: the pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        if (pressed && (col[pcol] == 1'b0)) row[prow] = 1'b0;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_strobe === 1'b1) begin n_strobe++; strb_cyc = cyc; end
        if (value_valid === 1'b1) begin n_vv++; vv_cyc = cyc; end
        if (entry_error === 1'b1) begin n_err++; err_cyc = cyc; end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // mode 0: normal press/release; 1: reset while held; 2: reset right after strobe
    task automatic press(input logic [3:0] k, input int hold, input int mode);
        bit got;
        case (k)
            4'd1: begin prow = 0; pcol = 0; end
            4'd2: begin prow = 0; pcol = 1; end
            4'd3: begin prow = 0; pcol = 2; end
            4'd4: begin prow = 1; pcol = 0; end
            4'd5: begin prow = 1; pcol = 1; end
            4'd6: begin prow = 1; pcol = 2; end
            4'd7: begin prow = 2; pcol = 0; end
            4'd8: begin prow = 2; pcol = 1; end
            4'd9: begin prow = 2; pcol = 2; end
            4'd0: begin prow = 3; pcol = 1; end
            4'd10: begin prow = 0; pcol = 3; end
            default: begin prow = 1; pcol = 3; end
        endcase
        pressed = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (key_strobe === 1'b1) got = 1'b1;
        end
        check("strobe_seen", {15'd0, got}, 16'd1);
        check("strobe_code", {12'd0, key_code}, {12'd0, k});
        if (mode == 2) begin
            pressed = 1'b0; rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
            return;
        end
        repeat (hold) @(negedge clk);
        if (mode == 1) begin
            rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; pressed = 1'b0;
            return;
        end
        pressed = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, {12'd0, col}, 16'h000E);
        check({tag, "_key_code"}, {12'd0, key_code}, 16'd0);
        check({tag, "_strobe"}, {15'd0, key_strobe}, 16'd0);
        check({tag, "_entry"}, entry_bcd, 16'h0000);
        check({tag, "_value"}, value, 16'h0000);
        check({tag, "_vv"}, {15'd0, value_valid}, 16'd0);
        check({tag, "_err"}, {15'd0, entry_error}, 16'd0);
    endtask

    initial begin
        int s0, v0, e0;
        logic [3:0] c1;
        bit found;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single key held 20 ticks: exactly one strobe
        press(4'd5, 80, 0);
        check("hold_strobes", 16'(n_strobe), 16'd1);
        check("hold_entry", entry_bcd, 16'h0005);
        press(4'd10, 4, 0);
        check("clear_entry", entry_bcd, 16'h0000);

        // 12:34 -> 754 s
        press(4'd1, 4, 0); press(4'd2, 4, 0); press(4'd3, 4, 0); press(4'd4, 4, 0);
        check("entry_1234", entry_bcd, 16'h1234);
        press(4'd11, 4, 0);
        check("value_754", value, 16'h02F2);
        check("vv_count1", 16'(n_vv), 16'd1);
        check("vv_latency", 16'(vv_cyc - strb_cyc), 16'd2);
        check("entry_cleared", entry_bcd, 16'h0000);

        // 01:75 rejected
        press(4'd0, 4, 0); press(4'd1, 4, 0); press(4'd7, 4, 0); press(4'd5, 4, 0);
        press(4'd11, 4, 0);
        check("err_count", 16'(n_err), 16'd1);
        check("err_latency", 16'(err_cyc - strb_cyc), 16'd2);
        check("err_value_kept", value, 16'h02F2);
        check("err_entry_kept", entry_bcd, 16'h0175);
        check("err_no_vv", 16'(n_vv), 16'd1);

        // Five digits: oldest discarded, then clear
        press(4'd9, 4, 0); press(4'd9, 4, 0); press(4'd5, 4, 0); press(4'd9, 4, 0); press(4'd3, 4, 0);
        check("entry_9593", entry_bcd, 16'h9593);
        press(4'd10, 4, 0);
        check("clear2_entry", entry_bcd, 16'h0000);
        check("clear2_value", value, 16'h02F2);

        // Boundary S1 = 5: 00:59 -> 59 s
        press(4'd0, 4, 0); press(4'd0, 4, 0); press(4'd5, 4, 0); press(4'd9, 4, 0);
        press(4'd11, 4, 0);
        check("value_59", value, 16'h003B);
        check("vv_count2", 16'(n_vv), 16'd2);

        // One-tick glitch on row0/col0: no strobe, scanning resumes
        s0 = n_strobe;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin @(negedge clk); if (col != 4'b1110) found = 1'b1; end
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin @(negedge clk); if (col == 4'b1110) found = 1'b1; end
        check("glitch_sync", {15'd0, found}, 16'd1);
        prow = 2'd0; pcol = 2'd0; pressed = 1'b1;
        repeat (4) @(negedge clk);
        pressed = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_no_strobe", 16'(n_strobe - s0), 16'd0);
        c1 = col;
        repeat (4) @(negedge clk);
        check("glitch_rotate", {12'd0, col}, {12'd0, c1[2:0], c1[3]});

        // Reset while HELD
        press(4'd5, 20, 1);
        check_reset_outputs("rst_held");
        repeat (40) @(negedge clk);

        // Reset in the cycle after an enter strobe
        press(4'd1, 4, 0); press(4'd2, 4, 0); press(4'd3, 4, 0); press(4'd4, 4, 0);
        v0 = n_vv; e0 = n_err;
        press(4'd11, 4, 2);
        check_reset_outputs("rst_enter");
        repeat (40) @(negedge clk);
        check("rst_enter_no_vv", 16'(n_vv - v0), 16'd0);
        check("rst_enter_no_err", 16'(n_err - e0), 16'd0);
        check("rst_enter_value", value, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_time_entry.md
KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per column-scan tick.
REQ-002 Parameter DEBOUNCE_TICKS, default 4: consecutive scan ticks a key must stay stable before it is accepted or released.
REQ-003 clk  in  1  system clock; every register updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 row  in  4  keypad row sense, active-low; a pressed key pulls its row low while its column is driven low.
REQ-006 col  out  4  keypad column drive, active-low one-hot.
REQ-007 key_code  out  4  code of the last accepted key: 0-9 digits, 10 = A (clear), 11 = B (enter), 12-15 = C, D, *, #.
REQ-008 key_strobe  out  1  one-cycle pulse when a key is accepted.
REQ-009 entry_bcd  out  16  digits entered so far as {M1,M0,S1,S0} BCD, for echo on the 7-segment display.
REQ-010 value  out  16  last committed time in seconds.
REQ-011 value_valid  out  1  one-cycle pulse when value updates.
REQ-012 entry_error  out  1  one-cycle pulse when enter is rejected.

Function
REQ-013 The prescaler shall count 0..SCAN_DIV-1 and emit a one-cycle scan tick on wrap.
REQ-014 In SCAN, col shall rotate on each tick through 1110, 1101, 1011, 0111, then back to 1110.
REQ-015 On a tick in SCAN, if any row bit is low, the FSM shall latch column index and lowest-numbered low row, freeze col, and enter DEBOUNCE.
REQ-016 In DEBOUNCE, if the latched row stays low for DEBOUNCE_TICKS consecutive ticks, the FSM shall enter HELD, update key_code, and pulse key_strobe once; if the row goes high first, it shall return to SCAN with no strobe.
REQ-017 In HELD, col shall stay frozen, and the FSM shall return to SCAN after all rows read high for DEBOUNCE_TICKS consecutive ticks; a low reading restarts the count.
REQ-018 Holding a key shall give exactly one strobe; auto-repeat is not provided.
REQ-019 Key code = row*4 + col mapped through the fixed layout: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = *,0,#,D.
REQ-020 On a digit strobe, entry_bcd shall shift left one nibble with the new digit in [3:0]; the oldest digit is discarded after 4 entries.
REQ-021 On clear (A), entry_bcd shall be 0 on the next cycle; value is unchanged.
REQ-022 On enter (B), if S1 <= 5, value shall become (M1*10+M0)*60 + S1*10+S0 exactly two cycles after key_strobe, with value_valid high in that same cycle, and entry_bcd shall clear.
REQ-023 On enter with S1 > 5, value shall be unchanged, entry_error shall pulse in the cycle value_valid would have pulsed, and entry_bcd shall be kept.
REQ-024 Arithmetic shall be unsigned; the maximum result is 5999 (16'h176F); no overflow handling is required.
REQ-025 Keys C, D, * and # shall strobe key_strobe but otherwise be ignored.
REQ-026 The accepted code shall map to exactly one action; only one key is processed at a time, and other keys pressed in DEBOUNCE or HELD are ignored.

Reset
REQ-027 While rst_n is low at a clk edge, the FSM shall go to SCAN, col to 1110, prescaler and debounce counters to 0, key_code, entry_bcd and value to 0, and all strobes to 0.
REQ-028 Reset during DEBOUNCE or HELD, or with a conversion pending, shall abort it with no strobe, value_valid or entry_error afterwards.

Structure
REQ-029 A shared package shall hold key-code constants (KEY_CLEAR = 10, KEY_ENTER = 11), the FSM state encoding (SCAN, DEBOUNCE, HELD) and the key layout table.
REQ-030 Prescaler, column FSM and debounce shall form one sub-module, keypad_scanner, with outputs col, key_code and key_strobe; entry and conversion logic stay in the top.

Verification (SCAN_DIV = 4, DEBOUNCE_TICKS = 2)
REQ-031 Press row1/col1 (key 5) for 20 ticks, then release -> exactly one key_strobe, key_code = 5, entry_bcd = 16'h0005.
REQ-032 Enter 1,2,3,4 then B -> value = 754 (16'h02F2), value_valid pulses 2 cycles after B strobe, entry_bcd = 0.
REQ-033 Enter 0,1,7,5 then B -> entry_error pulses, value unchanged, entry_bcd = 16'h0175.
REQ-034 Row low for 1 tick only -> no key_strobe; FSM returns to SCAN with col rotating.
REQ-035 Enter 9,9,5,9,3 -> entry_bcd = 16'h9593; then A -> entry_bcd = 0 and value unchanged.
REQ-036 Assert rst_n = 0 in HELD and in the cycle after a B strobe -> all outputs at reset values, no value_valid.
